reg_file_8x8: RTL and testbench
===============================

Name: reg_file_8x8

Overview:
- 8-entry x 8-bit register file for the 8-bit single-cycle processor.
- Sits directly upstream of the ALU and its function units (AND, OR, ADD, MOV).
- Supplies the two signed operands (OUT1 -> ALU A, OUT2 -> ALU B) and stores the ALU result C on the clock edge.
- Two asynchronous read ports, one synchronous write port.

Parameters:
- DATA_W, 8, register and port data width in bits.
- ADDR_W, 3, register address width.
- NUM_REGS, 8, number of registers; must equal 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_N  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- IN  input  DATA_W  write data, signed; driven from the ALU result.
- INADDRESS  input  ADDR_W  destination register index.
- WRITE  input  1  write enable, active high.
- OUT1ADDRESS  input  ADDR_W  read port 1 register index.
- OUT2ADDRESS  input  ADDR_W  read port 2 register index.
- OUT1  output  DATA_W  read port 1 data, signed; feeds ALU operand A.
- OUT2  output  DATA_W  read port 2 data, signed; feeds ALU operand B.

Behaviour:
- Storage: NUM_REGS registers of DATA_W bits, indices 0..NUM_REGS-1. Register 0 is an ordinary register, not hardwired to zero.
- Reset:
  - Fixed: one clock (CLK); synchronous, active-low reset (RESET_N).
  - On a CLK rising edge with RESET_N=0, every register becomes 0.
  - WRITE is ignored in that cycle; reset has priority over write.
  - Asserting reset between edges does not change storage; the clear happens at the next edge.
- Outputs at reset: OUT1/OUT2 are not registered. After the reset edge they read 0 for any address.
- Write:
  - On a CLK rising edge with RESET_N=1 and WRITE=1, reg[INADDRESS] <= IN.
  - WRITE=0 leaves all registers unchanged.
  - IN, INADDRESS and WRITE are sampled only at the edge; changes between edges have no effect.
- Read:
  - OUT1 = reg[OUT1ADDRESS] and OUT2 = reg[OUT2ADDRESS], purely combinational, zero-cycle latency.
  - Both ports may address the same register, including the register being written.
- Read-during-write, same address (feature off): OUT shows the old value until the edge, then the new value in the same delta after the edge.
- Write latency: the value is visible on the read ports 1 cycle after presentation, i.e. immediately after the capturing edge.
- Width/sign: no arithmetic; data stored bit-exact. Signedness affects only how consumers interpret the value.
- Full range: every address value is legal, so no out-of-range case exists when NUM_REGS = 2**ADDR_W.
- Handshake: none. The decoder guarantees WRITE is stable around the edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If RESET_N=1, WRITE=1 and OUTxADDRESS==INADDRESS, then OUTx = IN combinationally before the edge. Each port is independent.
- Not defined: no forwarding; reads always return stored contents.
- Storage timing is identical in both builds.

Decomposition:
- Package reg_file_pkg holds:
  - localparams DATA_W=8, ADDR_W=3, NUM_REGS=8;
  - typedef data_t (signed [DATA_W-1:0]);
  - typedef addr_t ([ADDR_W-1:0]).
- ALU function units reuse data_t from the same package.
- Sub-module reg_file_read_port: address-indexed mux plus the optional bypass compare. Instantiated twice (OUT1, OUT2).

Test Plan:
- Reset: assert RESET_N=0 for one edge with WRITE=1, IN=8'h55, INADDRESS=3 -> all 8 registers read 0 on both ports; reg3 != 8'h55.
- Write/read all: write reg[i]=i*17 for i=0..7 (one per cycle) -> after the final edge, sweep OUT1ADDRESS/OUT2ADDRESS 0..7 and read matching values, both ports.
- Same register on both ports: reg5=8'b11010100, OUT1ADDRESS=OUT2ADDRESS=5 -> OUT1=OUT2=-44 (signed).
- Read-during-write: reg2=10; WRITE=1, INADDRESS=2, IN=11, OUT1ADDRESS=2.
  - Without the macro: OUT1=10 before the edge, 11 after.
  - With REGFILE_BYPASS_EN: OUT1=11 before the edge.
- WRITE=0 hold: reg4=15; present IN=8'hFF, INADDRESS=4, WRITE=0 for 3 edges -> reg4 stays 15.
- Reset mid-program: registers loaded; pulse RESET_N low between edges, then high before the edge -> contents unchanged. Hold it low across an edge -> all zero.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types for the 8-bit datapath: register file and ALU function units.
package reg_file_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic        [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/reg_file_8x8_if.sv
// Register file access bus: one write port and two read ports.
interface reg_file_8x8_if;
  import reg_file_pkg::*;

  data_t IN;
  addr_t INADDRESS;
  logic  WRITE;
  addr_t OUT1ADDRESS;
  addr_t OUT2ADDRESS;
  data_t OUT1;
  data_t OUT2;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2
  );
endinterface

// File: rtl/reg_file_read_port.sv
// Asynchronous read port: address mux, with write-through forwarding when
// REGFILE_BYPASS_EN is defined.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  data_t [NUM_REGS-1:0] regs,
  input  addr_t                raddr,
`ifdef REGFILE_BYPASS_EN
  input  logic                 fwd_en,
  input  addr_t                waddr,
  input  data_t                wdata,
`endif
  output data_t                rdata
);

  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
    // A pending write to the same index is shown before it is stored.
    if (fwd_en && (waddr == raddr)) rdata = wdata;
`endif
  end

endmodule

// File: rtl/reg_file_8x8.sv
// 8x8 register file: two combinational read ports, one synchronous write port.
// Optional build macro REGFILE_BYPASS_EN adds write-through forwarding on reads.
module reg_file_8x8
  import reg_file_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET_N,
  reg_file_8x8_if.slave  bus
);

  data_t [NUM_REGS-1:0] regs;

  // Reset has priority over a write presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      regs <= '0;
    end else if (bus.WRITE) begin
      regs[bus.INADDRESS] <= bus.IN;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_en;
  assign fwd_en = RESET_N & bus.WRITE;
`endif

  reg_file_read_port u_rd1 (
    .regs   (regs),
    .raddr  (bus.OUT1ADDRESS),
`ifdef REGFILE_BYPASS_EN
    .fwd_en (fwd_en),
    .waddr  (bus.INADDRESS),
    .wdata  (bus.IN),
`endif
    .rdata  (bus.OUT1)
  );

  reg_file_read_port u_rd2 (
    .regs   (regs),
    .raddr  (bus.OUT2ADDRESS),
`ifdef REGFILE_BYPASS_EN
    .fwd_en (fwd_en),
    .waddr  (bus.INADDRESS),
    .wdata  (bus.IN),
`endif
    .rdata  (bus.OUT2)
  );

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: vector table plus hand-written corner sequences.
module tb_reg_file_8x8;
  import reg_file_pkg::*;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  reg_file_8x8_if bus ();

  reg_file_8x8 dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    logic  wr;
    addr_t wa;
    data_t wd;
    addr_t a1;
    addr_t a2;
    data_t e1;
    data_t e2;
  } vec_t;

  vec_t vt[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input addr_t a1, input addr_t a2);
    bus.OUT1ADDRESS = a1;
    bus.OUT2ADDRESS = a2;
    #1;
  endtask

  task automatic wr(input addr_t a, input data_t d);
    bus.WRITE     = 1'b1;
    bus.INADDRESS = a;
    bus.IN        = d;
    tick();
    bus.WRITE     = 1'b0;
  endtask

  initial begin
    vec_t v;
    data_t exp_pre;

    // Vector table: write reg[i]=i*17, then sweep, then signed same-register read.
    for (int i = 0; i < 8; i++) begin
      v.wr = 1'b1; v.wa = addr_t'(i); v.wd = data_t'(i * 17);
      v.a1 = addr_t'(i); v.a2 = addr_t'(i);
      v.e1 = data_t'(i * 17); v.e2 = data_t'(i * 17);
      vt.push_back(v);
    end
    for (int j = 0; j < 8; j++) begin
      v.wr = 1'b0; v.wa = 3'd0; v.wd = 8'sh7F;
      v.a1 = addr_t'(j); v.a2 = addr_t'(7 - j);
      v.e1 = data_t'(j * 17); v.e2 = data_t'((7 - j) * 17);
      vt.push_back(v);
    end
    v.wr = 1'b1; v.wa = 3'd5; v.wd = 8'b11010100;
    v.a1 = 3'd5; v.a2 = 3'd5; v.e1 = -8'sd44; v.e2 = -8'sd44;
    vt.push_back(v);

    RESET_N = 1'b1;
    bus.WRITE = 1'b0;
    bus.IN = '0;
    bus.INADDRESS = '0;
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;
    tick();

    // Reset wins over a concurrent write.
    RESET_N = 1'b0;
    bus.WRITE = 1'b1;
    bus.IN = 8'sh55;
    bus.INADDRESS = 3'd3;
    tick();
    RESET_N = 1'b1;
    bus.WRITE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(addr_t'(i), addr_t'(i));
      check($sformatf("reset_out1[%0d]", i), bus.OUT1, 8'sd0);
      check($sformatf("reset_out2[%0d]", i), bus.OUT2, 8'sd0);
    end

    // Table: drive row, capture on the edge, drop WRITE, read back.
    foreach (vt[k]) begin
      bus.WRITE       = vt[k].wr;
      bus.INADDRESS   = vt[k].wa;
      bus.IN          = vt[k].wd;
      bus.OUT1ADDRESS = vt[k].a1;
      bus.OUT2ADDRESS = vt[k].a2;
      tick();
      bus.WRITE = 1'b0;
      #1;
      check($sformatf("vec%0d_out1", k), bus.OUT1, vt[k].e1);
      check($sformatf("vec%0d_out2", k), bus.OUT2, vt[k].e2);
    end

    // Read-during-write on the same address.
    wr(3'd2, 8'sd10);
    rd(3'd2, 3'd0);
    bus.WRITE = 1'b1;
    bus.INADDRESS = 3'd2;
    bus.IN = 8'sd11;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 8'sd11;
`else
    exp_pre = 8'sd10;
`endif
    check("rdw_before_edge", bus.OUT1, exp_pre);
    check("rdw_other_port", bus.OUT2, 8'sd0);
    tick();
    check("rdw_after_edge", bus.OUT1, 8'sd11);
    bus.WRITE = 1'b0;
    #1;
    check("rdw_stored", bus.OUT1, 8'sd11);

    // WRITE=0 holds contents regardless of IN/INADDRESS.
    wr(3'd4, 8'sd15);
    rd(3'd4, 3'd4);
    bus.WRITE = 1'b0;
    bus.INADDRESS = 3'd4;
    bus.IN = 8'shFF;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("hold_out1_%0d", n), bus.OUT1, 8'sd15);
      check($sformatf("hold_out2_%0d", n), bus.OUT2, 8'sd15);
    end

    // Reset pulse between edges must not clear storage.
    @(negedge CLK);
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    tick();
    rd(3'd4, 3'd7);
    check("pulse_reg4", bus.OUT1, 8'sd15);
    check("pulse_reg7", bus.OUT2, 8'sd119);
    rd(3'd2, 3'd5);
    check("pulse_reg2", bus.OUT1, 8'sd11);
    check("pulse_reg5", bus.OUT2, -8'sd44);

    // Reset held across an edge clears everything.
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(addr_t'(i), addr_t'(7 - i));
      check($sformatf("clr_out1[%0d]", i), bus.OUT1, 8'sd0);
      check($sformatf("clr_out2[%0d]", i), bus.OUT2, 8'sd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
